// File: rtl/if_id_fifo_pkg.sv
// Shared widths for the fetch->decode path and the IF/ID queue defaults.
package if_id_fifo_pkg;

    localparam int unsigned INST_ADDR_BUS  = 32;
    localparam int unsigned INST_BUS       = 32;
    localparam int unsigned EXCEP_TYPE_BUS = 6;
    localparam int unsigned IF_ID_DEPTH    = 4;

    // Width of a pointer into a queue of the given depth (at least one bit).
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/if_id_fifo_ptr_ctrl.sv
// Read/write pointers, occupancy and full/empty flags for a DEPTH-entry queue.
// Arbitrary DEPTH >= 2; pointers wrap by explicit compare. Reused by the store buffer.
module fifo_ptr_ctrl
    import if_id_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH = IF_ID_DEPTH,
    localparam int unsigned PTR_W = ptr_width(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Flush outranks any handshake in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count <= FULL_CNT);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && empty));

endmodule

// File: rtl/if_id_fifo.sv
// Fetch->decode decoupling queue with valid/ready on both sides.
// First-word-fall-through head; ID sees an all-zero NOP while empty.
module if_id_fifo
    import if_id_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH  = IF_ID_DEPTH,
    parameter  int unsigned ADDR_W = INST_ADDR_BUS,
    parameter  int unsigned INST_W = INST_BUS,
    parameter  int unsigned EXC_W  = EXCEP_TYPE_BUS,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_instr,
    input  logic [EXC_W-1:0]  if_exception_type,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_instr,
    output logic [EXC_W-1:0]  id_exception_type,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned ENT_W = ADDR_W + INST_W + EXC_W;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;

    // Ready comes from registered occupancy only, so a pop never frees a slot in the same cycle.
    assign if_ready = ~full;
    assign id_valid = ~empty;
    assign push     = if_valid & ~full & ~flush;
    assign pop      = ~empty & id_ready & ~flush;

    fifo_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .push   (push),
        .pop    (pop),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // Storage is deliberately not reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {if_pc, if_instr, if_exception_type};
        end
    end

    assign head = empty ? '0 : mem[rd_ptr];
    assign {id_pc, id_instr, id_exception_type} = head;

endmodule

// File: tb/tb_if_id_fifo.sv
// Randomized bench for if_id_fifo: DEPTH=4 and DEPTH=3 instances share stimulus,
// each compared every cycle against a queue-based reference model.
module tb_if_id_fifo;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  exc;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [5:0]  if_exception_type;

    logic        if_ready4, id_valid4, if_ready3, id_valid3;
    logic [31:0] id_pc4, id_instr4, id_pc3, id_instr3;
    logic [5:0]  id_exc4, id_exc3;
    logic [2:0]  count4;
    logic [1:0]  count3;

    ent_t m4[$];
    ent_t m3[$];

    int checks = 0;
    int errors = 0;

    if_id_fifo #(.DEPTH(4)) u_d4 (
        .clk (clk), .rst (rst), .flush (flush),
        .if_valid (if_valid), .if_ready (if_ready4),
        .if_pc (if_pc), .if_instr (if_instr), .if_exception_type (if_exception_type),
        .id_valid (id_valid4), .id_ready (id_ready),
        .id_pc (id_pc4), .id_instr (id_instr4), .id_exception_type (id_exc4),
        .count (count4)
    );

    if_id_fifo #(.DEPTH(3)) u_d3 (
        .clk (clk), .rst (rst), .flush (flush),
        .if_valid (if_valid), .if_ready (if_ready3),
        .if_pc (if_pc), .if_instr (if_instr), .if_exception_type (if_exception_type),
        .id_valid (id_valid3), .id_ready (id_ready),
        .id_pc (id_pc3), .id_instr (id_instr3), .id_exception_type (id_exc3),
        .count (count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Compare every visible output of both instances with the model queues.
    task automatic check_all();
        ent_t h4;
        ent_t h3;
        h4 = (m4.size() != 0) ? m4[0] : '0;
        h3 = (m3.size() != 0) ? m3[0] : '0;
        check("d4_count",    64'(count4),    64'(m4.size()));
        check("d4_if_ready", 64'(if_ready4), 64'(m4.size() != 4));
        check("d4_id_valid", 64'(id_valid4), 64'(m4.size() != 0));
        check("d4_id_pc",    64'(id_pc4),    64'(h4.pc));
        check("d4_id_instr", 64'(id_instr4), 64'(h4.instr));
        check("d4_id_exc",   64'(id_exc4),   64'(h4.exc));
        check("d3_count",    64'(count3),    64'(m3.size()));
        check("d3_if_ready", 64'(if_ready3), 64'(m3.size() != 3));
        check("d3_id_valid", 64'(id_valid3), 64'(m3.size() != 0));
        check("d3_id_pc",    64'(id_pc3),    64'(h3.pc));
        check("d3_id_instr", 64'(id_instr3), 64'(h3.instr));
        check("d3_id_exc",   64'(id_exc3),   64'(h3.exc));
    endtask

    // One clock: drive inputs, check mid-cycle, advance the model at the edge.
    task automatic step(input bit f, input bit iv, input bit ir,
                        input logic [31:0] pc, input logic [31:0] ins, input logic [5:0] exc);
        ent_t e;
        bit   w4;
        bit   w3;
        flush             = f;
        if_valid          = iv;
        id_ready          = ir;
        if_pc             = pc;
        if_instr          = ins;
        if_exception_type = exc;
        #4;
        check_all();
        @(posedge clk);
        e = '{pc: pc, instr: ins, exc: exc};
        if (f) begin
            m4.delete();
            m3.delete();
        end else begin
            w4 = iv && (m4.size() < 4);
            w3 = iv && (m3.size() < 3);
            if (ir && m4.size() != 0) void'(m4.pop_front());
            if (ir && m3.size() != 0) void'(m3.pop_front());
            if (w4) m4.push_back(e);
            if (w3) m3.push_back(e);
        end
        #1;
    endtask

    // Reset asserted between edges must clear outputs without waiting for the clock.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        m4.delete();
        m3.delete();
        check("arst_count4",   64'(count4),    64'd0);
        check("arst_id_valid", 64'(id_valid4), 64'd0);
        check("arst_id_instr", 64'(id_instr4), 64'd0);
        check("arst_if_ready", 64'(if_ready4), 64'd1);
        check("arst_count3",   64'(count3),    64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        if_valid = 1'b0;
        id_ready = 1'b0;
        if_pc = '0;
        if_instr = '0;
        if_exception_type = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Fill with id_ready low, then drain in order.
        for (int k = 0; k < 4; k++)
            step(0, 1, 0, 32'hBFC0_0000 + 32'(4 * k), 32'h1000 + 32'(k), 6'h0);
        check("fill_count4", 64'(count4), 64'd4);
        check("fill_ready4", 64'(if_ready4), 64'd0);
        for (int k = 0; k < 4; k++)
            step(0, 0, 1, 32'h0, 32'h0, 6'h0);

        // Streaming at occupancy 2.
        step(0, 1, 0, 32'h100, 32'hA0, 6'h0);
        step(0, 1, 0, 32'h104, 32'hA1, 6'h0);
        for (int k = 0; k < 20; k++)
            step(0, 1, 1, 32'h108 + 32'(4 * k), 32'hA2 + 32'(k), 6'(k));
        check("stream_count4", 64'(count4), 64'd2);

        // Full with simultaneous pop: no push until a slot is free.
        step(0, 1, 0, 32'h200, 32'hB0, 6'h0);
        step(0, 1, 0, 32'h204, 32'hB1, 6'h0);
        step(0, 1, 1, 32'h208, 32'hB2, 6'h0);
        check("fullpop_count4", 64'(count4), 64'd3);
        step(0, 1, 1, 32'h208, 32'hB2, 6'h0);
        check("pushpop_count4", 64'(count4), 64'd3);

        // Flush with push and pop requested in the same cycle.
        step(1, 1, 1, 32'hDEAD_0000, 32'hDEAD, 6'h3F);
        check("flush_count4", 64'(count4), 64'd0);
        check("flush_valid4", 64'(id_valid4), 64'd0);

        // Exception passthrough, including across the DEPTH=3 wrap.
        step(0, 1, 0, 32'h300, 32'hC0, 6'h04);
        check("exc_head4", 64'(id_exc4), 64'h04);
        check("exc_head3", 64'(id_exc3), 64'h04);
        for (int k = 0; k < 8; k++)
            step(0, 1, 1, 32'h304 + 32'(4 * k), 32'hC1 + 32'(k), 6'(k + 1));

        // Reset in the middle of a burst.
        step(0, 1, 0, 32'h400, 32'hD0, 6'h1);
        async_reset();
        step(0, 0, 0, 32'h0, 32'h0, 6'h0);

        // Randomized traffic with rare flushes and one more mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) async_reset();
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0), $urandom, $urandom, 6'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
